float16_dot_accumulator: RTL and testbench
==========================================

// Module: float16_dot_accumulator
// PURPOSE
//   Sequential reduction stage of the dot-product datapath. Sits directly
//   downstream of the element-wise float16 multiplier and wraps one
//   combinational float16_adder instance. Sums a stream of VEC_LEN float16
//   products into one float16 result, presented on a valid/ready output port.
// PARAMETERS
//   VEC_LEN  8                     products per dot product, >= 1
//   CNT_W    $clog2(VEC_LEN+1)     width of the beat counter (derived; do not override)
// PORTS
//   clk        in   1   single clock; all state updates on posedge
//   rst        in   1   synchronous, active-high reset
//   in_valid   in   1   in_data holds a valid product
//   in_ready   out  1   block accepts in_data this cycle
//   in_data    in   16  IEEE-754 binary16 product (sign, exp[4:0], mant[9:0])
//   flush      in   1   synchronous abort of the vector in progress
//   out_valid  out  1   out_data holds the finished dot product
//   out_ready  in   1   consumer accepts out_data this cycle
//   out_data   out  16  binary16 sum of the VEC_LEN accepted products
//   busy       out  1   high while a vector is partially accumulated (ACCUM)
// BEHAVIOUR
//   Reset (rst=1 at posedge; overrides all other inputs):
//     - state=IDLE, acc=16'h0000, cnt=0
//     - in_ready=1, out_valid=0, out_data=16'h0000, busy=0
//   Beat and handshakes
//     - input beat = in_valid && in_ready
//     - output beat = out_valid && out_ready
//     - in_ready = (state != DONE). Combinational from state only.
//   Accumulate on each input beat
//     - acc <= float16_adder(acc_or_zero, in_data)
//     - acc_or_zero = 16'h0000 in IDLE, acc otherwise
//     - cnt <= cnt + 1
//     - rounding, overflow, Inf and NaN follow float16_adder unchanged; no extra handling
//   FSM
//     - IDLE : beat with VEC_LEN==1 -> DONE; other beat -> ACCUM; no beat -> stay
//     - ACCUM: beat with cnt==VEC_LEN-1 -> DONE; other beat -> stay; idle cycles hold acc/cnt
//     - DONE : out_valid=1, out_data=acc, held stable while out_ready=0
//     - DONE : output beat -> IDLE, acc<=0, cnt<=0
//   Latency and throughput
//     - out_valid rises the cycle after the last product is accepted
//     - 1 product/cycle while streaming
//     - min period VEC_LEN+1 cycles per result; no input is accepted in DONE
//   flush (ignored while rst=1)
//     - in IDLE or ACCUM: state->IDLE, acc<=0, cnt<=0; the same-cycle input beat is discarded
//     - in DONE: no effect; the pending result is never dropped
//   Reset mid-vector or in DONE discards all state, including a pending result.
//   out_data = acc at all times; only valid when out_valid=1.
// TESTING  (VEC_LEN=4 unless noted)
//   1. 4x 16'h3C00 (1.0), back-to-back -> out_valid on 5th cycle, out_data=16'h4400 (4.0)
//   2. 16'h4300, 16'h4100, 16'hC300, 16'h3C00 (3.5, 2.5, -3.5, 1.0) with gaps in in_valid
//      -> out_data=16'h4300 (3.5); busy=1 only between 1st and 4th beat
//   3. out_ready=0 for 5 cycles in DONE
//      -> out_data stable, in_ready=0, in_valid beats ignored; new vector accepted after release
//   4. flush after 2 beats of 16'h4000, then 4x 16'h3C00 -> out_data=16'h4400 (no residue)
//   5. rst pulse in ACCUM and in DONE -> next cycle all outputs at reset values, then a clean 4x 1.0 -> 16'h4400
//   6. VEC_LEN=1, stream 16'h4600, 16'hBC00, out_ready=1
//      -> results 16'h4600 then 16'hBC00, each one cycle after its accept

Source files
------------

// File: rtl/float16_dot_accumulator.sv
// Float16 dot-product reduction stage: sums VEC_LEN binary16 products through one
// combinational adder and offers the result on a valid/ready port.

module float16_adder (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);

   logic        swap;
   logic [15:0] big, sml;
   logic [4:0]  eb, es, d;
   logic [10:0] mb, ms;
   logic [42:0] wide;
   logic [13:0] bg, al;
   logic [14:0] s_raw, s;
   logic [5:0]  e, lz, sh;
   logic        rnd;
   logic [4:0]  ef;
   logic [14:0] sum;
   logic        a_nan, b_nan, a_inf, b_inf;

   always_comb begin
      a_nan = (a[14:10] == 5'h1f) && (a[9:0] != '0);
      b_nan = (b[14:10] == 5'h1f) && (b[9:0] != '0);
      a_inf = (a[14:10] == 5'h1f) && (a[9:0] == '0);
      b_inf = (b[14:10] == 5'h1f) && (b[9:0] == '0);

      swap = a[14:0] < b[14:0];
      big  = swap ? b : a;
      sml  = swap ? a : b;
      eb   = (big[14:10] == '0) ? 5'd1 : big[14:10];
      es   = (sml[14:10] == '0) ? 5'd1 : sml[14:10];
      mb   = {big[14:10] != '0, big[9:0]};
      ms   = {sml[14:10] != '0, sml[9:0]};
      d    = eb - es;

      // 32 spare bits keep every shifted-out bit visible to the sticky OR
      wide  = {ms, 32'b0} >> d;
      al    = {wide[42:30], |wide[29:0]};
      bg    = {mb, 3'b000};
      s_raw = (big[15] == sml[15]) ? ({1'b0, bg} + {1'b0, al}) : ({1'b0, bg} - {1'b0, al});

      s  = s_raw;
      e  = {1'b0, eb};
      lz = 6'd14;
      sh = '0;
      if (s_raw[14]) begin
         s = {1'b0, s_raw[14:2], s_raw[1] | s_raw[0]};
         e = e + 6'd1;
      end else begin
         for (int unsigned i = 0; i < 14; i++) begin
            if (s_raw[i]) lz = 6'(13 - i);
         end
         // never shift below the subnormal exponent
         sh = (lz < e - 6'd1) ? lz : e - 6'd1;
         s  = s_raw << sh;
         e  = e - sh;
      end

      rnd = s[2] & (s[1] | s[0] | s[3]);
      ef  = s[13] ? e[4:0] : 5'd0;
      // carry out of the mantissa walks into the exponent, including up to Inf
      sum = {ef, s[12:3]} + 15'(rnd);

      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
         y = 16'h7e00;
      else if (a_inf)
         y = a;
      else if (b_inf)
         y = b;
      else if (s_raw == '0)
         y = {a[15] & b[15], 15'h0000};
      else if (e >= 6'd31)
         y = {big[15], 15'h7c00};
      else
         y = {big[15], sum};
   end

endmodule

module float16_dot_accumulator #(
   parameter int VEC_LEN = 8,
   parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t             state;
   logic [15:0]        acc;
   logic [CNT_W-1:0]   cnt;
   logic [15:0]        acc_or_zero;
   logic [15:0]        sum;

   assign acc_or_zero = (state == IDLE) ? 16'h0000 : acc;

   float16_adder u_add (
      .a (acc_or_zero),
      .b (in_data),
      .y (sum)
   );

   assign in_ready  = (state != DONE);
   assign out_valid = (state == DONE);
   assign busy      = (state == ACCUM);
   assign out_data  = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (flush) begin
                  state <= IDLE;
                  acc   <= '0;
                  cnt   <= '0;
               end else if (in_valid) begin
                  acc <= sum;
                  cnt <= cnt + CNT_W'(1);
                  state <= (cnt == CNT_W'(VEC_LEN - 1)) ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_float16_dot_accumulator.sv
// Randomized and directed bench for float16_dot_accumulator (VEC_LEN=4 and VEC_LEN=1)
// against a real-arithmetic binary16 reference model.

module tb_float16_dot_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[2], in_valid[2], flush[2], out_ready[2];
   logic        in_ready[2], out_valid[2], busy[2];
   logic [15:0] in_data[2], out_data[2];

   int checks = 0;
   int failures = 0;
   bit armed = 1'b0;

   float16_dot_accumulator #(.VEC_LEN(4)) dut4 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .flush(flush[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
   );

   float16_dot_accumulator #(.VEC_LEN(1)) dut1 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .flush(flush[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
   );

   // ---------------- reference arithmetic ----------------
   function automatic real pow2(int n);
      real p = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
      else        for (int i = 0; i < -n; i++) p = p / 2.0;
      return p;
   endfunction

   function automatic real to_real(logic [15:0] h);
      real v;
      if (h[14:10] == 5'd0) v = real'(h[9:0]) * pow2(-24);
      else                  v = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -v : v;
   endfunction

   function automatic int rne(real q);
      real fl = $floor(q);
      real fr = q - fl;
      int  r  = $rtoi(fl);
      if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r = r + 1;
      return r;
   endfunction

   function automatic logic [15:0] round16(real x);
      bit  sg = (x < 0.0);
      real mag = sg ? -x : x;
      int  e = 0;
      real p = 1.0;
      int  q;
      while (mag >= 2.0 * p) begin p = p * 2.0; e++; end
      while (mag < p)        begin p = p / 2.0; e--; end
      if (e < -14) begin
         q = rne(mag * pow2(24));
         return {sg, 15'(q)};
      end
      q = rne(mag * pow2(10 - e));
      if (q == 2048) begin q = 1024; e++; end
      if (e > 15) return {sg, 15'h7c00};
      return {sg, 5'(e + 15), 10'(q - 1024)};
   endfunction

   function automatic logic [15:0] ref_add(logic [15:0] a, logic [15:0] b);
      bit  an = (a[14:10] == 5'h1f) && (a[9:0] != 0);
      bit  bn = (b[14:10] == 5'h1f) && (b[9:0] != 0);
      bit  ai = (a[14:10] == 5'h1f) && (a[9:0] == 0);
      bit  bi = (b[14:10] == 5'h1f) && (b[9:0] == 0);
      real x;
      if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7e00;
      if (ai) return a;
      if (bi) return b;
      x = to_real(a) + to_real(b);
      if (x == 0.0) return {a[15] & b[15], 15'h0000};
      return round16(x);
   endfunction

   // ---------------- checking ----------------
   task automatic chk(string name, int k, logic [15:0] act, logic [15:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, k, act, want, $time);
      end
   endtask

   logic [15:0] m_acc[2];
   int          m_n[2];
   bit          m_pend[2];
   int          vlen[2] = '{4, 1};

   // behavioural model: running sum of accepted products, result pending until taken
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst[k]) begin
            m_acc[k] = 16'h0000; m_n[k] = 0; m_pend[k] = 1'b0;
         end else if (m_pend[k]) begin
            if (out_ready[k]) begin m_acc[k] = 16'h0000; m_n[k] = 0; m_pend[k] = 1'b0; end
         end else if (flush[k]) begin
            m_acc[k] = 16'h0000; m_n[k] = 0;
         end else if (in_valid[k]) begin
            m_acc[k] = ref_add(m_acc[k], in_data[k]);
            m_n[k]++;
            if (m_n[k] == vlen[k]) m_pend[k] = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         for (int k = 0; k < 2; k++) begin
            chk("in_ready",  k, {15'd0, in_ready[k]},  {15'd0, !m_pend[k]});
            chk("out_valid", k, {15'd0, out_valid[k]}, {15'd0, m_pend[k]});
            chk("busy",      k, {15'd0, busy[k]},      {15'd0, (m_n[k] > 0) && !m_pend[k]});
            chk("out_data",  k, out_data[k], m_acc[k]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(int k, bit v, logic [15:0] d, bit orr, bit fl);
      in_valid[k] = v; in_data[k] = d; out_ready[k] = orr; flush[k] = fl;
      @(negedge clk);
   endtask

   task automatic get_result(int k, logic [15:0] want, string name);
      int n = 0;
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; flush[k] = 1'b0;
      while (!out_valid[k] && n < 20) begin @(negedge clk); n++; end
      if (!out_valid[k]) chk({name, "_timeout"}, k, {15'd0, out_valid[k]}, 16'h0001);
      else               chk(name, k, out_data[k], want);
      cyc(k, 1'b0, 16'h0000, 1'b1, 1'b0);
      out_ready[k] = 1'b0;
   endtask

   task automatic chk_reset_state(int k, string name);
      chk({name, "_in_ready"},  k, {15'd0, in_ready[k]},  16'h0001);
      chk({name, "_out_valid"}, k, {15'd0, out_valid[k]}, 16'h0000);
      chk({name, "_out_data"},  k, out_data[k],           16'h0000);
      chk({name, "_busy"},      k, {15'd0, busy[k]},      16'h0000);
   endtask

   function automatic logic [15:0] rand16();
      int r = $urandom_range(0, 31);
      logic [15:0] specials[5] = '{16'h7c00, 16'hfc00, 16'h7e01, 16'h0000, 16'h8000};
      if (r == 0) return specials[$urandom_range(0, 4)];
      if (r == 1) return {1'($urandom), 5'd0, 10'($urandom)};
      return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = 16'h0000;
         flush[k] = 1'b0; out_ready[k] = 1'b0;
      end
      @(negedge clk); @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      armed = 1'b1;
      chk_reset_state(0, "reset");
      chk_reset_state(1, "reset");

      // model pins
      chk("pin_1p1",   0, ref_add(16'h3c00, 16'h3c00), 16'h4000);
      chk("pin_3p5",   0, ref_add(16'h4300, 16'h4100), 16'h4600);
      chk("pin_sub",   0, ref_add(16'h4600, 16'hc300), 16'h4100);
      chk("pin_tie",   0, ref_add(16'h6800, 16'h3c00), 16'h6800);
      chk("pin_ovf",   0, ref_add(16'h7bff, 16'h7bff), 16'h7c00);
      chk("pin_zero",  0, ref_add(16'h3c00, 16'hbc00), 16'h0000);
      chk("pin_denrm", 0, ref_add(16'h0001, 16'h0001), 16'h0002);

      // 1: four 1.0 back to back
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      chk("t1_valid", 0, {15'd0, out_valid[0]}, 16'h0001);
      get_result(0, 16'h4400, "t1_sum");

      // 2: gaps in in_valid
      cyc(0, 1'b1, 16'h4300, 1'b0, 1'b0);
      chk("t2_busy_on", 0, {15'd0, busy[0]}, 16'h0001);
      cyc(0, 1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(0, 1'b1, 16'h4100, 1'b0, 1'b0);
      cyc(0, 1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(0, 1'b0, 16'h0000, 1'b0, 1'b0);
      cyc(0, 1'b1, 16'hc300, 1'b0, 1'b0);
      cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      chk("t2_busy_off", 0, {15'd0, busy[0]}, 16'h0000);
      get_result(0, 16'h4300, "t2_sum");

      // 3: back-pressure in DONE
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      repeat (5) begin
         cyc(0, 1'b1, 16'h4000, 1'b0, 1'b0);
         chk("t3_hold", 0, out_data[0], 16'h4400);
         chk("t3_in_ready", 0, {15'd0, in_ready[0]}, 16'h0000);
      end
      get_result(0, 16'h4400, "t3_sum");
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      get_result(0, 16'h4400, "t3_next");

      // 4: flush mid-vector, same-cycle beat discarded
      repeat (2) cyc(0, 1'b1, 16'h4000, 1'b0, 1'b0);
      cyc(0, 1'b1, 16'h4000, 1'b0, 1'b1);
      chk("t4_flushed", 0, out_data[0], 16'h0000);
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      get_result(0, 16'h4400, "t4_sum");

      // 5: reset in ACCUM and in DONE
      repeat (2) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      rst[0] = 1'b1;
      cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      rst[0] = 1'b0;
      chk_reset_state(0, "t5_accum");
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      rst[0] = 1'b1;
      cyc(0, 1'b0, 16'h0000, 1'b0, 1'b0);
      rst[0] = 1'b0;
      chk_reset_state(0, "t5_done");
      repeat (4) cyc(0, 1'b1, 16'h3c00, 1'b0, 1'b0);
      get_result(0, 16'h4400, "t5_sum");

      // 6: VEC_LEN=1 streaming
      cyc(1, 1'b1, 16'h4600, 1'b1, 1'b0);
      chk("t6_v0", 1, {15'd0, out_valid[1]}, 16'h0001);
      chk("t6_d0", 1, out_data[1], 16'h4600);
      cyc(1, 1'b1, 16'hbc00, 1'b1, 1'b0);
      chk("t6_gap", 1, {15'd0, out_valid[1]}, 16'h0000);
      cyc(1, 1'b1, 16'hbc00, 1'b1, 1'b0);
      chk("t6_v1", 1, {15'd0, out_valid[1]}, 16'h0001);
      chk("t6_d1", 1, out_data[1], 16'hbc00);
      cyc(1, 1'b0, 16'h0000, 1'b1, 1'b0);

      // random traffic on both instances
      for (int n = 0; n < 4000; n++) begin
         for (int k = 0; k < 2; k++) begin
            rst[k]       = ($urandom_range(0, 255) == 0);
            flush[k]     = ($urandom_range(0, 31) == 0);
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_data[k]   = rand16();
            out_ready[k] = ($urandom_range(0, 2) != 0);
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
